// File: rtl/hub75_pkg.sv
// Shared types and width/offset helpers for the HUB75 frame buffer.
package hub75_pkg;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  function automatic int unsigned calc_aw(input int unsigned cols, input int unsigned rows);
    return $clog2(cols * rows);
  endfunction

  function automatic int unsigned calc_pix_w(input int unsigned r_bits, input int unsigned g_bits,
                                             input int unsigned b_bits);
    return r_bits + g_bits + b_bits;
  endfunction

  function automatic int unsigned calc_pw(input int unsigned planes);
    return (planes > 1) ? $clog2(planes) : 1;
  endfunction

  function automatic int unsigned g_offset(input int unsigned r_bits);
    return r_bits;
  endfunction

  function automatic int unsigned b_offset(input int unsigned r_bits, input int unsigned g_bits);
    return r_bits + g_bits;
  endfunction

  // Channel MSB lands on plane planes-1; planes below the channel's range read as 0.
  function automatic logic plane_bit(input logic [31:0] chan, input int unsigned n,
                                     input int unsigned planes, input int unsigned p);
    logic [31:0] sh;
    if (p + n >= planes) begin
      sh = chan >> (p + n - planes);
      return sh[0];
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/hub75_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on contents.
module hub75_dp_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16384
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Same-address read/write returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/hub75_frame_buffer.sv
// Double-buffered HUB75 frame buffer: pixel writes to the back bank, bit-plane reads of
// upper/lower scan rows from the front bank, frame-synchronised swap and back-bank clear.
module hub75_frame_buffer
  import hub75_pkg::*;
#(
  parameter int unsigned COLS          = 512,
  parameter int unsigned ROWS          = 64,
  parameter int unsigned R_BITS        = 5,
  parameter int unsigned G_BITS        = 6,
  parameter int unsigned B_BITS        = 5,
  parameter int unsigned PLANES        = 8,
  parameter int unsigned DOUBLE_BUFFER = 1,
  localparam int unsigned AW           = calc_aw(COLS, ROWS),
  localparam int unsigned PIX_W        = calc_pix_w(R_BITS, G_BITS, B_BITS),
  localparam int unsigned PW           = calc_pw(PLANES)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-2:0]    rd_addr,
  input  logic [PW-1:0]    rd_plane,
  output logic             r0,
  output logic             g0,
  output logic             b0,
  output logic             r1,
  output logic             g1,
  output logic             b1,
  output logic             rd_valid,
  input  logic             frame_sync,
  input  logic             swap_req,
  output logic             swap_done,
  output logic             front_bank,
  input  logic             clear_req,
  output logic             clear_busy
);

  localparam int unsigned DEPTH = COLS * ROWS / 2;
  localparam int unsigned HAW   = AW - 1;
  localparam int unsigned NB    = (DOUBLE_BUFFER != 0) ? 2 : 1;
  localparam int unsigned G_OFF = g_offset(R_BITS);
  localparam int unsigned B_OFF = b_offset(R_BITS, G_BITS);

  state_e         state_q, state_d;
  logic [HAW-1:0] clr_cnt_q, clr_cnt_d;
  logic           pending_q, pending_d;
  logic           front_d, swap_done_d, take;

  assign clear_busy = (state_q == StClear);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
      StClear: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == HAW'(DEPTH - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A frame_sync during a clear leaves the request pending for a later frame.
  always_comb begin
    take        = frame_sync && (pending_q || swap_req) && !clear_busy;
    pending_d   = (pending_q || swap_req) && !take;
    front_d     = (take && DOUBLE_BUFFER != 0) ? ~front_bank : front_bank;
    swap_done_d = take;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      clr_cnt_q  <= '0;
      pending_q  <= 1'b0;
      front_bank <= 1'b0;
      swap_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      pending_q  <= pending_d;
      front_bank <= front_d;
      swap_done  <= swap_done_d;
    end
  end

  logic           wr_bank;
  logic [HAW-1:0] ram_waddr;
  logic [PIX_W-1:0] ram_wdata;
  logic [PIX_W-1:0] rd_pix [2][2];

  assign wr_bank   = (DOUBLE_BUFFER != 0) ? ~front_bank : front_bank;
  assign ram_waddr = clear_busy ? clr_cnt_q : wr_addr[AW-2:0];
  assign ram_wdata = clear_busy ? '0 : wr_data;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar h = 0; h < 2; h++) begin : g_half
      if (b < NB) begin : g_ram
        logic we;
        assign we = (wr_bank == 1'(b)) &&
                    (clear_busy || (wr_en && (wr_addr[AW-1] == 1'(h))));
        hub75_dp_ram #(
          .WIDTH(PIX_W),
          .DEPTH(DEPTH)
        ) u_ram (
          .clk   (clk),
          .we    (we),
          .waddr (ram_waddr),
          .wdata (ram_wdata),
          .re    (rd_en),
          .raddr (rd_addr),
          .rdata (rd_pix[b][h])
        );
      end else begin : g_none
        assign rd_pix[b][h] = '0;
      end
    end
  end

  logic          rd_v1_q;
  logic          rd_bank_q;
  logic [PW-1:0] rd_plane_q;
  logic [PIX_W-1:0] up_pix, lo_pix;

  assign up_pix = rd_pix[rd_bank_q][0];
  assign lo_pix = rd_pix[rd_bank_q][1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_v1_q    <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_plane_q <= '0;
      rd_valid   <= 1'b0;
      {r0, g0, b0, r1, g1, b1} <= '0;
    end else begin
      rd_v1_q  <= rd_en;
      rd_valid <= rd_v1_q;
      if (rd_en) begin
        rd_bank_q  <= front_bank;
        rd_plane_q <= rd_plane;
      end
      if (rd_v1_q) begin
        r0 <= plane_bit(32'(up_pix[R_BITS-1:0]),     R_BITS, PLANES, 32'(rd_plane_q));
        g0 <= plane_bit(32'(up_pix[G_OFF +: G_BITS]), G_BITS, PLANES, 32'(rd_plane_q));
        b0 <= plane_bit(32'(up_pix[B_OFF +: B_BITS]), B_BITS, PLANES, 32'(rd_plane_q));
        r1 <= plane_bit(32'(lo_pix[R_BITS-1:0]),     R_BITS, PLANES, 32'(rd_plane_q));
        g1 <= plane_bit(32'(lo_pix[G_OFF +: G_BITS]), G_BITS, PLANES, 32'(rd_plane_q));
        b1 <= plane_bit(32'(lo_pix[B_OFF +: B_BITS]), B_BITS, PLANES, 32'(rd_plane_q));
      end
    end
  end

endmodule

// File: tb/tb_hub75_frame_buffer.sv
// Directed self-checking bench for hub75_frame_buffer with default parameters.
module tb_hub75_frame_buffer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [13:0] rd_addr;
  logic [2:0]  rd_plane;
  logic        r0, g0, b0, r1, g1, b1, rd_valid;
  logic        frame_sync, swap_req, swap_done, front_bank, clear_req, clear_busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  hub75_frame_buffer u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_plane   (rd_plane),
    .r0         (r0),
    .g0         (g0),
    .b0         (b0),
    .r1         (r1),
    .g1         (g1),
    .b1         (b1),
    .rd_valid   (rd_valid),
    .frame_sync (frame_sync),
    .swap_req   (swap_req),
    .swap_done  (swap_done),
    .front_bank (front_bank),
    .clear_req  (clear_req),
    .clear_busy (clear_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] rd_word();
    return {rd_valid, r0, g0, b0, r1, g1, b1};
  endfunction

  task automatic write_pix(input logic [14:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic swap_now();
    swap_req = 1'b1; frame_sync = 1'b1;
    tick();
    swap_req = 1'b0; frame_sync = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [13:0] a, input logic [2:0] p,
                            input logic [6:0] exp);
    rd_en = 1'b1; rd_addr = a; rd_plane = p;
    tick();
    rd_en = 1'b0;
    check({tag, "_t1_valid"}, 32'(rd_valid), 32'd0);
    tick();
    check(tag, 32'(rd_word()), 32'(exp));
  endtask

  int unsigned n;
  logic        seen;
  logic [6:0]  exp_w;

  initial begin
    resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
    rd_plane = '0; frame_sync = 1'b0; swap_req = 1'b0; clear_req = 1'b0;
    tick(); tick();
    check("rst_front", 32'(front_bank), 32'd0);
    check("rst_swap_done", 32'(swap_done), 32'd0);
    check("rst_clear_busy", 32'(clear_busy), 32'd0);
    check("rst_rd", 32'(rd_word()), 32'd0);
    resetn = 1'b1;
    tick();

    // Test 1: white pixel in upper half of bank 1, then display it.
    write_pix(15'h0005, 16'hFFFF);
    write_pix(15'h4005, 16'h0000);
    swap_now();
    check("t1_front", 32'(front_bank), 32'd1);
    check("t1_swap_done", 32'(swap_done), 32'd1);
    tick();
    check("t1_swap_done_pulse", 32'(swap_done), 32'd0);
    // Back-to-back reads: plane 7 then plane 2.
    rd_en = 1'b1; rd_addr = 14'h0005; rd_plane = 3'd7;
    tick();
    rd_plane = 3'd2;
    tick();
    rd_en = 1'b0;
    check("t1_plane7", 32'(rd_word()), 32'(7'b1111000));
    tick();
    check("t1_plane2", 32'(rd_word()), 32'(7'b1010000));
    tick();
    check("t1_idle_hold", 32'(rd_word()), 32'(7'b0010000));
    read_check("t1_plane0", 14'h0005, 3'd0, 7'b1000000);

    // Test 2: pure green in lower half of bank 0.
    write_pix(15'h4005, 16'h07E0);
    write_pix(15'h0005, 16'h0000);
    swap_now();
    check("t2_front", 32'(front_bank), 32'd0);
    for (int p = 0; p < 8; p++) begin
      exp_w = {1'b1, 3'b000, 1'b0, (p >= 2), 1'b0};
      read_check($sformatf("t2_plane%0d", p), 14'h0005, 3'(p), exp_w);
    end

    // Test 3: request held pending until a frame_sync arrives.
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (swap_done || front_bank) seen = 1'b1;
    end
    check("t3_no_swap", 32'(seen), 32'd0);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("t3_front", 32'(front_bank), 32'd1);
    check("t3_swap_done", 32'(swap_done), 32'd1);
    tick();
    check("t3_swap_done_pulse", 32'(swap_done), 32'd0);

    // Tests 4/5: clear bank 0; write and swap during the clear must not land.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    n = 0;
    while (clear_busy && n < 20000) begin
      n++;
      clear_req  = (n == 50);
      wr_en      = (n == 100);
      wr_addr    = 15'h0007;
      wr_data    = 16'hFFFF;
      swap_req   = (n == 200);
      frame_sync = (n == 200);
      tick();
      if (n == 200) begin
        check("t5_no_swap_done", 32'(swap_done), 32'd0);
        check("t5_front_held", 32'(front_bank), 32'd1);
      end
    end
    clear_req = 1'b0; wr_en = 1'b0; swap_req = 1'b0; frame_sync = 1'b0;
    check("t4_busy_cycles", n, 32'd16384);
    check("t4_busy_low", 32'(clear_busy), 32'd0);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("t5_swap_done", 32'(swap_done), 32'd1);
    check("t5_front", 32'(front_bank), 32'd0);
    read_check("t4_addr5", 14'h0005, 3'd7, 7'b1000000);
    read_check("t4_addr7", 14'h0007, 3'd7, 7'b1000000);
    read_check("t4_addr5_p2", 14'h0005, 3'd2, 7'b1000000);

    // Test 6: reset mid-clear with a swap pending.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick();
    swap_req = 1'b1; rd_en = 1'b1;
    tick();
    swap_req = 1'b0;
    check("t6_busy_before", 32'(clear_busy), 32'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1; rd_en = 1'b0;
    check("t6_clear_busy", 32'(clear_busy), 32'd0);
    check("t6_front", 32'(front_bank), 32'd0);
    check("t6_rd_valid", 32'(rd_valid), 32'd0);
    tick();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("t6_no_swap_done", 32'(swap_done), 32'd0);
    check("t6_front_after", 32'(front_bank), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
